// File: rtl/mips_program_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words and writes them into
// instruction memory, holding the CPU in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module mips_program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        ImemWrite,
  output logic [31:0] ImemAddr,
  output logic [31:0] ImemData,
  output logic        CpuReset,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // State entered once the image body has been written (or is empty).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [31:0] DEPTH_W = 32'(MEMORY_DEPTH);

  state_t      state_r;
  logic [15:0] count_r;
  logic [15:0] index_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] word_r;
  logic [15:0] hdr_count_s;
  logic        byte_xfer_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  chk_r;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

  assign hdr_count_s = {count_r[15:8], ByteIn};
  assign byte_xfer_s = ByteValid && ByteReady;
  assign ImemAddr    = BASE_ADDR + {14'd0, index_r, 2'b00};
  assign ImemData    = word_r;

  // Status and handshake outputs decoded from the state register.
  always_comb begin
    ByteReady = 1'b0;
    ImemWrite = 1'b0;
    CpuReset  = 1'b1;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state_r)
      S_HDR0, S_HDR1, S_DATA: ByteReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                  ByteReady = 1'b1;
`endif
      S_WRITE:                ImemWrite = 1'b1;
      S_DONE: begin
        CpuReset = 1'b0;
        Done     = 1'b1;
      end
      S_ERR:                  Error = 1'b1;
      default:                ByteReady = 1'b0;
    endcase
  end

  // Loader FSM with header, word-assembly and checksum datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_HDR0;
      count_r    <= 16'd0;
      index_r    <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_HDR0: begin
          if (byte_xfer_s) begin
            count_r[15:8] <= ByteIn;
            state_r       <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (byte_xfer_s) begin
            count_r[7:0] <= ByteIn;
            index_r      <= 16'd0;
            byte_cnt_r   <= 2'd0;
            if (hdr_count_s == 16'd0) begin
              state_r <= S_FIN;
            end else if (32'(hdr_count_s) > DEPTH_W) begin
              state_r <= S_ERR;
            end else begin
              state_r <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_xfer_s) begin
            word_r     <= {word_r[23:0], ByteIn};
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk_r      <= chk_fold(chk_r, ByteIn);
`endif
            if (byte_cnt_r == 2'd3) begin
              state_r <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // count_r is at least 1 here, so index_r + 1 cannot overflow past it.
          if ((index_r + 16'd1) < count_r) begin
            index_r <= index_r + 16'd1;
            state_r <= S_DATA;
          end else begin
            state_r <= S_FIN;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (byte_xfer_s) begin
            state_r <= (ByteIn == chk_r) ? S_DONE : S_ERR;
          end
        end
`endif
        S_DONE:  state_r <= S_DONE;
        S_ERR:   state_r <= S_ERR;
        default: state_r <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Randomized self-checking bench for mips_program_loader against a stream-level reference model.
module tb_mips_program_loader;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        ImemWrite;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        CpuReset;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] words_q[$];
  bit          exp_done;

  mips_program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .ImemWrite(ImemWrite), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .CpuReset(CpuReset), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: byte stream plus expected (addr,data) writes and final outcome from words_q.
  task automatic make_load(input int n, input bit bad_chk);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'd0;
    stream_q.delete();
    exp_q.delete();
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    if (n > DEPTH) begin
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int b = 0; b < 4; b++) begin
        stream_q.push_back(w[31 - 8 * b -: 8]);
        sum = sum ^ w[31 - 8 * b -: 8];
      end
      exp_q.push_back({BASE + 32'(i) * 32'd4, w});
    end
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(bad_chk ? (sum ^ 8'h01) : sum);
`endif
    exp_done = !bad_chk;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset     = 1'b1;
    ByteValid = 1'b0;
    ByteIn    = 8'd0;
    @(negedge clk);
    if (chk) begin
      check_eq("rst_ready", 32'(ByteReady), 32'd1);
      check_eq("rst_write", 32'(ImemWrite), 32'd0);
      check_eq("rst_addr", ImemAddr, BASE);
      check_eq("rst_data", ImemData, 32'd0);
      check_eq("rst_cpureset", 32'(CpuReset), 32'd1);
      check_eq("rst_done", 32'(Done), 32'd0);
      check_eq("rst_error", 32'(Error), 32'd0);
    end
    reset = 1'b0;
  endtask

  task automatic run_stream(input bit gaps, input string name);
    int          idx = 0;
    int          wr = 0;
    int          cyc = 0;
    int          exp_total;
    bit          prev_wr = 1'b0;
    bit          prev_last = 1'b0;
    bit          seen = 1'b0;
    bit          acc;
    logic [63:0] e;
    exp_total = exp_q.size();
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (ImemWrite) begin
        if (wr >= exp_total) begin
          check_eq({name, "_extra_write"}, 32'(wr + 1), 32'(exp_total));
        end else begin
          e = exp_q.pop_front();
          check_eq({name, "_addr"}, ImemAddr, e[63:32]);
          check_eq({name, "_data"}, ImemData, e[31:0]);
          check_eq({name, "_bytes_before_write"}, 32'(idx - 2), 32'(4 * (wr + 1)));
        end
        wr++;
      end
      if (Done || Error) begin
        seen = 1'b1;
        if (Done) begin
`ifdef LOADER_CHECKSUM_EN
          check_eq({name, "_done_after_chk"}, 32'(prev_last), 32'd1);
`else
          if (exp_total > 0) check_eq({name, "_done_after_write"}, 32'(prev_wr), 32'd1);
          else check_eq({name, "_done_after_hdr"}, 32'(prev_last), 32'd1);
`endif
        end
      end else begin
        if (idx < stream_q.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
          ByteValid = 1'b1;
          ByteIn    = stream_q[idx];
        end else begin
          ByteValid = 1'b0;
          ByteIn    = 8'($urandom());
        end
        #1;
        acc = ByteValid && ByteReady;
        if (acc) idx++;
        prev_last = acc && (idx == stream_q.size());
      end
      prev_wr = ImemWrite;
      cyc++;
    end
    ByteValid = 1'b0;
    check_eq({name, "_finished"}, 32'(seen), 32'd1);
    check_eq({name, "_done"}, 32'(Done), 32'(exp_done));
    check_eq({name, "_error"}, 32'(Error), 32'(!exp_done));
    check_eq({name, "_cpureset"}, 32'(CpuReset), 32'(!exp_done));
    check_eq({name, "_ready"}, 32'(ByteReady), 32'd0);
    check_eq({name, "_write_count"}, 32'(wr), 32'(exp_total));
  endtask

  initial begin
    int n;
    int idx;
    int wr;
    reset     = 1'b0;
    ByteValid = 1'b0;
    ByteIn    = 8'd0;

    do_reset(1'b1);
    words_q = '{32'h2008_0005, 32'h0000_000C};
    make_load(2, 1'b0);
    run_stream(1'b0, "two_words");

    do_reset(1'b0);
    words_q.delete();
    make_load(33, 1'b0);
    run_stream(1'b0, "too_big");

    do_reset(1'b1);
    make_load(0, 1'b0);
    run_stream(1'b1, "empty");

`ifdef LOADER_CHECKSUM_EN
    do_reset(1'b0);
    words_q = '{32'h1122_3344};
    make_load(1, 1'b1);
    run_stream(1'b0, "bad_chk");
    do_reset(1'b0);
    make_load(1, 1'b0);
    run_stream(1'b0, "good_chk");
`endif

    // Largest legal image, gapped.
    do_reset(1'b0);
    words_q.delete();
    for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom());
    make_load(DEPTH, 1'b0);
    run_stream(1'b1, "full_depth");

    for (int t = 0; t < 4; t++) begin
      do_reset(1'b0);
      words_q.delete();
      for (int i = 0; i < 3; i++) words_q.push_back($urandom());
      make_load(3, 1'b0);
      run_stream(1'b1, "gapped3");
    end

    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      n = $urandom_range(1, DEPTH);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom());
      make_load(n, 1'b0);
      run_stream(1'b1, "rand_n");
    end

    // Reset after two data bytes; the abandoned word must never be written.
    do_reset(1'b0);
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    idx = 0;
    wr  = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (ImemWrite) wr++;
      ByteValid = 1'b1;
      ByteIn    = stream_q[idx];
      #1;
      if (ByteReady) idx++;
    end
    @(negedge clk);
    ByteValid = 1'b0;
    if (ImemWrite) wr++;
    check_eq("partial_no_write", 32'(wr), 32'd0);
    do_reset(1'b0);
    check_eq("partial_reset_addr", ImemAddr, BASE);
    words_q = '{32'h8C09_0004};
    make_load(1, 1'b0);
    run_stream(1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
